// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl
//   Pedestrian-side initiator for the traffic controller's button/light
//   interface. Conditions the raw crossing pushbutton (2-flop synchroniser
//   plus debouncer), turns an accepted press into a held request on the
//   controller's button input, watches the light lines for service and
//   measures how long the request waited.
//
//   Optional feature macro: LIGHT_CHECK_EN
//     defined   -> illegal light combinations set the sticky light_err flag
//     undefined -> checker absent, light_err tied low
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive equal synced samples to accept a new level
//   TIMEOUT_CYCLES   request cycles before timeout_err is raised
//   CNT_W            wait_count width (TIMEOUT_CYCLES <= 2**CNT_W-1)
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   btn_raw          raw pushbutton, asynchronous, may bounce
//   green_c/yellow_c/red_c   car lights from the controller
//   green_p/yellow_p/red_p   pedestrian lights from the controller
//   button           registered request to the controller
//   wait_lamp        WAIT indicator, high while the request is pending
//   wait_count       cycles spent requesting; holds last value after exit
//   timeout_err      sticky, request unserved for TIMEOUT_CYCLES
//   light_err        sticky, illegal light combination seen
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             green_c,
    input  logic             yellow_c,
    input  logic             red_c,
    input  logic             green_p,
    input  logic             yellow_p,
    input  logic             red_p,
    output logic             button,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] wait_count,
    output logic             timeout_err,
    output logic             light_err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic            btn_s1;
    logic            btn_s2;
    logic [DB_W-1:0] db_cnt;
    logic            btn_db;
    logic            btn_db_q;
    logic            press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
        end
    end

    // db_cnt counts consecutive synced samples that disagree with btn_db.
    // A sample that agrees again (i.e. the synced level changed back)
    // restarts the run, so only a level held for DEBOUNCE_CYCLES samples
    // is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s2 != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   wc_clear;
    logic   wc_inc;
    logic   to_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wc_clear   = 1'b0;
        wc_inc     = 1'b0;
        to_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A press that coincides with pedestrian green is dropped.
                if (press && !green_p) begin
                    next_state = ST_REQ;
                    wc_clear   = 1'b1;
                end
            end
            ST_REQ: begin
                // The flag is raised on the edge where the count arrives at
                // TIMEOUT_CYCLES (or is already there). It is raised even when
                // service arrives on that same cycle.
                if (wait_count >= TIMEOUT_PRE) begin
                    to_set = 1'b1;
                end
                if (green_p) begin
                    // Count freezes at the value it had when service came.
                    next_state = ST_SERVE;
                end else if (wait_count != TIMEOUT_VAL) begin
                    wc_inc = 1'b1;
                end
            end
            ST_SERVE: begin
                if (!green_p) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (red_p) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so button and wait_lamp are
    // glitch-free flops that change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button      <= 1'b0;
            wait_lamp   <= 1'b0;
            wait_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            button    <= (next_state == ST_REQ);
            wait_lamp <= (next_state == ST_REQ);
            if (wc_clear) begin
                wait_count <= '0;
            end else if (wc_inc) begin
                wait_count <= wait_count + 1'b1;
            end
            if (to_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Light sanity checker
    // ------------------------------------------------------------------
`ifdef LIGHT_CHECK_EN
    logic car_multi;
    logic ped_multi;
    logic both_green;

    // "Two or more of three" is the OR of the pairwise ANDs.
    assign car_multi  = (green_c & yellow_c) | (green_c & red_c) | (yellow_c & red_c);
    assign ped_multi  = (green_p & yellow_p) | (green_p & red_p) | (yellow_p & red_p);
    assign both_green = green_c & green_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_err <= 1'b0;
        end else if (car_multi || ped_multi || both_green) begin
            light_err <= 1'b1;
        end
    end
`else
    // Car lights and pedestrian yellow only feed the checker.
    logic unused_lights;
    assign unused_lights = ^{green_c, yellow_c, red_c, yellow_p};
    assign light_err     = 1'b0;
`endif

endmodule
